// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
package pipe_hazard_ctrl_pkg;

   // EXE operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Controller states: idle, extra load-use bubbles, multi-cycle op in EXE
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      LD_WAIT = 2'b01,
      MC_BUSY = 2'b10
   } hz_state_e;

   // Default parameter values
   localparam int DEF_RA_W     = 5;
   localparam int DEF_LOAD_LAT = 1;
   localparam int DEF_MC_LAT   = 4;
   localparam int DEF_CNT_W    = 16;

   // Down-counter widths sized for LOAD_LAT <= 7 and MC_LAT <= 15
   localparam int LD_CNT_W = 3;
   localparam int MC_CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, else increment unless already at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand
// forwarding, load-use stalls, multi-cycle op stalls, branch/jump flushes
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int RA_W     = DEF_RA_W,
   parameter int LOAD_LAT = DEF_LOAD_LAT,
   parameter int MC_LAT   = DEF_MC_LAT,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RA_W-1:0]  id_rs_i,
   input  logic [RA_W-1:0]  id_rt_i,
   input  logic             id_use_rs_i,
   input  logic             id_use_rt_i,
   input  logic [RA_W-1:0]  exe_rs_i,
   input  logic [RA_W-1:0]  exe_rt_i,
   input  logic [RA_W-1:0]  exe_rw_i,
   input  logic             exe_regwr_i,
   input  logic             exe_memtoreg_i,
   input  logic [RA_W-1:0]  mem_rw_i,
   input  logic             mem_regwr_i,
   input  logic             mem_memtoreg_i,
   input  logic [RA_W-1:0]  wb_rw_i,
   input  logic             wb_regwr_i,
   input  logic             exe_mc_start_i,
   input  logic             exe_branch_taken_i,
   input  logic             id_jump_i,
   input  logic             cnt_clr_i,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic             stall_pc_o,
   output logic             stall_if_id_o,
   output logic             stall_id_exe_o,
   output logic             bubble_id_exe_o,
   output logic             bubble_exe_mem_o,
   output logic             flush_if_id_o,
   output logic             mc_busy_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
);

   localparam logic [LD_CNT_W-1:0] LD_INIT = LD_CNT_W'(LOAD_LAT - 1);
   localparam logic [MC_CNT_W-1:0] MC_INIT = MC_CNT_W'(MC_LAT - 1);

   // ---------------- forwarding ----------------
   logic [RA_W-1:0] exe_src [2];
   logic [1:0]      fwd_sel [2];

   assign exe_src[0] = exe_rs_i;
   assign exe_src[1] = exe_rt_i;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         // MEM ALU result beats WB; register 0 is never forwarded
         always_comb begin
            fwd_sel[gi] = FWD_RF;
            if (mem_regwr_i && !mem_memtoreg_i && (mem_rw_i != '0) && (mem_rw_i == exe_src[gi])) begin
               fwd_sel[gi] = FWD_MEM;
            end else if (wb_regwr_i && (wb_rw_i != '0) && (wb_rw_i == exe_src[gi])) begin
               fwd_sel[gi] = FWD_WB;
            end
         end
      end
   endgenerate

   assign fwd_a_o = fwd_sel[0];
   assign fwd_b_o = fwd_sel[1];

   // ---------------- hazard FSM ----------------
   hz_state_e             state_q, state_d;
   logic [LD_CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
   logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
   logic                  lu;
   logic                  stall_pc, stall_if_id, stall_id_exe;
   logic                  bubble_id_exe, bubble_exe_mem, flush_if_id;

   assign lu = exe_regwr_i && exe_memtoreg_i && (exe_rw_i != '0) &&
               ((id_use_rs_i && (id_rs_i == exe_rw_i)) ||
                (id_use_rt_i && (id_rt_i == exe_rw_i)));

   // Next state and stall/flush decisions; priority mc > branch > load-use > jump
   always_comb begin
      state_d        = state_q;
      ld_cnt_d       = ld_cnt_q;
      mc_cnt_d       = mc_cnt_q;
      stall_pc       = 1'b0;
      stall_if_id    = 1'b0;
      stall_id_exe   = 1'b0;
      bubble_id_exe  = 1'b0;
      bubble_exe_mem = 1'b0;
      flush_if_id    = 1'b0;
      case (state_q)
         IDLE: begin
            if (exe_mc_start_i) begin
               stall_pc       = 1'b1;
               stall_if_id    = 1'b1;
               stall_id_exe   = 1'b1;
               bubble_exe_mem = 1'b1;
               state_d        = MC_BUSY;
               mc_cnt_d       = MC_INIT;
            end else if (exe_branch_taken_i) begin
               flush_if_id    = 1'b1;
               bubble_id_exe  = 1'b1;
            end else if (lu) begin
               stall_pc       = 1'b1;
               stall_if_id    = 1'b1;
               bubble_id_exe  = 1'b1;
               if (LOAD_LAT > 1) begin
                  state_d  = LD_WAIT;
                  ld_cnt_d = LD_INIT;
               end
            end else if (id_jump_i) begin
               flush_if_id    = 1'b1;
            end
         end
         LD_WAIT: begin
            if (exe_branch_taken_i) begin
               flush_if_id    = 1'b1;
               bubble_id_exe  = 1'b1;
               state_d        = IDLE;
            end else begin
               stall_pc       = 1'b1;
               stall_if_id    = 1'b1;
               bubble_id_exe  = 1'b1;
               ld_cnt_d       = ld_cnt_q - LD_CNT_W'(1);
               if (ld_cnt_q == LD_CNT_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         MC_BUSY: begin
            stall_pc       = 1'b1;
            stall_if_id    = 1'b1;
            stall_id_exe   = 1'b1;
            bubble_exe_mem = 1'b1;
            mc_cnt_d       = mc_cnt_q - MC_CNT_W'(1);
            if (mc_cnt_q == MC_CNT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and down-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ld_cnt_q <= '0;
         mc_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         mc_cnt_q <= mc_cnt_d;
      end
   end

   // Control outputs are forced low while reset is asserted
   assign stall_pc_o       = rst_n & stall_pc;
   assign stall_if_id_o    = rst_n & stall_if_id;
   assign stall_id_exe_o   = rst_n & stall_id_exe;
   assign bubble_id_exe_o  = rst_n & bubble_id_exe;
   assign bubble_exe_mem_o = rst_n & bubble_exe_mem;
   assign flush_if_id_o    = rst_n & flush_if_id;
   assign mc_busy_o        = (state_q == MC_BUSY);

   // ---------------- performance counters ----------------
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (stall_pc_o),
      .clr_i (cnt_clr_i),
      .cnt_o (stall_cycles_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (flush_if_id_o),
      .clr_i (cnt_clr_i),
      .cnt_o (flush_count_o)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two controller instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share stimulus and are compared every cycle with a
// behavioural model that tracks remaining stall cycles as plain integers.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] id_rs, id_rt, exe_rs, exe_rt, exe_rw, mem_rw, wb_rw;
   logic id_use_rs, id_use_rt, exe_regwr, exe_memtoreg, mem_regwr, mem_memtoreg, wb_regwr;
   logic exe_mc_start, exe_branch_taken, id_jump, cnt_clr;

   logic [1:0] fwd_a [2];
   logic [1:0] fwd_b [2];
   logic       stall_pc [2], stall_if_id [2], stall_id_exe [2];
   logic       bubble_id_exe [2], bubble_exe_mem [2], flush_if_id [2], mc_busy [2];
   logic [15:0] sc0, fc0;
   logic [3:0]  sc1, fc1;
   logic [6:0]  dut_ctl [2];
   logic [31:0] dut_sc [2];
   logic [31:0] dut_fc [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int busy_seen = 0;

   // model state per instance
   int m_ld [2];
   int m_mc [2];
   int m_sc [2];
   int m_fc [2];
   logic [6:0] m_ctl [2];
   int LL [2] = '{1, 3};
   int ML [2] = '{4, 4};
   int CM [2] = '{65535, 15};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RA_W(5), .LOAD_LAT(1), .MC_LAT(4), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
      .exe_rs_i(exe_rs), .exe_rt_i(exe_rt), .exe_rw_i(exe_rw),
      .exe_regwr_i(exe_regwr), .exe_memtoreg_i(exe_memtoreg),
      .mem_rw_i(mem_rw), .mem_regwr_i(mem_regwr), .mem_memtoreg_i(mem_memtoreg),
      .wb_rw_i(wb_rw), .wb_regwr_i(wb_regwr),
      .exe_mc_start_i(exe_mc_start), .exe_branch_taken_i(exe_branch_taken),
      .id_jump_i(id_jump), .cnt_clr_i(cnt_clr),
      .fwd_a_o(fwd_a[0]), .fwd_b_o(fwd_b[0]),
      .stall_pc_o(stall_pc[0]), .stall_if_id_o(stall_if_id[0]), .stall_id_exe_o(stall_id_exe[0]),
      .bubble_id_exe_o(bubble_id_exe[0]), .bubble_exe_mem_o(bubble_exe_mem[0]),
      .flush_if_id_o(flush_if_id[0]), .mc_busy_o(mc_busy[0]),
      .stall_cycles_o(sc0), .flush_count_o(fc0)
   );

   pipe_hazard_ctrl #(.RA_W(5), .LOAD_LAT(3), .MC_LAT(4), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
      .exe_rs_i(exe_rs), .exe_rt_i(exe_rt), .exe_rw_i(exe_rw),
      .exe_regwr_i(exe_regwr), .exe_memtoreg_i(exe_memtoreg),
      .mem_rw_i(mem_rw), .mem_regwr_i(mem_regwr), .mem_memtoreg_i(mem_memtoreg),
      .wb_rw_i(wb_rw), .wb_regwr_i(wb_regwr),
      .exe_mc_start_i(exe_mc_start), .exe_branch_taken_i(exe_branch_taken),
      .id_jump_i(id_jump), .cnt_clr_i(cnt_clr),
      .fwd_a_o(fwd_a[1]), .fwd_b_o(fwd_b[1]),
      .stall_pc_o(stall_pc[1]), .stall_if_id_o(stall_if_id[1]), .stall_id_exe_o(stall_id_exe[1]),
      .bubble_id_exe_o(bubble_id_exe[1]), .bubble_exe_mem_o(bubble_exe_mem[1]),
      .flush_if_id_o(flush_if_id[1]), .mc_busy_o(mc_busy[1]),
      .stall_cycles_o(sc1), .flush_count_o(fc1)
   );

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pack
         assign dut_ctl[gi] = {stall_pc[gi], stall_if_id[gi], stall_id_exe[gi],
                               bubble_id_exe[gi], bubble_exe_mem[gi], flush_if_id[gi], mc_busy[gi]};
      end
   endgenerate
   assign dut_sc[0] = {16'h0, sc0};
   assign dut_fc[0] = {16'h0, fc0};
   assign dut_sc[1] = {28'h0, sc1};
   assign dut_fc[1] = {28'h0, fc1};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [1:0] m_fwd(input logic [4:0] src);
      if (mem_regwr && !mem_memtoreg && mem_rw != 0 && mem_rw == src) return 2'b01;
      if (wb_regwr && wb_rw != 0 && wb_rw == src) return 2'b10;
      return 2'b00;
   endfunction

   function automatic bit m_lu();
      return exe_regwr && exe_memtoreg && exe_rw != 0 &&
             ((id_use_rs && id_rs == exe_rw) || (id_use_rt && id_rt == exe_rw));
   endfunction

   // ctl bits: stall_pc, stall_if_id, stall_id_exe, bubble_id_exe, bubble_exe_mem, flush, mc_busy
   task automatic model_outputs(input int k);
      bit busy, idle;
      busy = (m_mc[k] > 0);
      idle = !busy && (m_ld[k] == 0);
      m_ctl[k] = 7'b0;
      if (!rst_n) return;
      m_ctl[k][0] = busy;
      if (busy || (idle && exe_mc_start))   m_ctl[k][6:2] = 5'b11101;
      else if (exe_branch_taken)            begin m_ctl[k][3] = 1'b1; m_ctl[k][1] = 1'b1; end
      else if (m_lu() || m_ld[k] > 0)       m_ctl[k][6:3] = 4'b1101;
      else if (id_jump)                     m_ctl[k][1] = 1'b1;
   endtask

   task automatic model_reset(input int k);
      m_ld[k] = 0; m_mc[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
   endtask

   task automatic model_step(input int k);
      bit busy, idle;
      if (!rst_n) begin model_reset(k); return; end
      busy = (m_mc[k] > 0);
      idle = !busy && (m_ld[k] == 0);
      if (busy)                       m_mc[k] = m_mc[k] - 1;
      else if (idle && exe_mc_start)  m_mc[k] = ML[k] - 1;
      else if (exe_branch_taken)      m_ld[k] = 0;
      else if (m_ld[k] > 0)           m_ld[k] = m_ld[k] - 1;
      else if (m_lu())                m_ld[k] = LL[k] - 1;
      if (cnt_clr) begin
         m_sc[k] = 0; m_fc[k] = 0;
      end else begin
         if (m_ctl[k][6] && m_sc[k] < CM[k]) m_sc[k]++;
         if (m_ctl[k][1] && m_fc[k] < CM[k]) m_fc[k]++;
      end
   endtask

   // One clock: inputs were driven at the preceding falling edge
   task automatic do_cycle();
      #1;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) model_reset(k);
         model_outputs(k);
         check($sformatf("u%0d.fwd_a", k), 32'(fwd_a[k]), 32'(m_fwd(exe_rs)));
         check($sformatf("u%0d.fwd_b", k), 32'(fwd_b[k]), 32'(m_fwd(exe_rt)));
         check($sformatf("u%0d.ctl", k), 32'(dut_ctl[k]), 32'(m_ctl[k]));
         check($sformatf("u%0d.stall_cycles", k), dut_sc[k], 32'(m_sc[k]));
         check($sformatf("u%0d.flush_count", k), dut_fc[k], 32'(m_fc[k]));
      end
      busy_seen += int'(mc_busy[0]);
      $display("cyc %0d rst_n=%b u0 ctl=%b sc=%0d fc=%0d | u1 ctl=%b sc=%0d fc=%0d",
               cyc, rst_n, dut_ctl[0], sc0, fc0, dut_ctl[1], sc1, fc1);
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
      exe_rs = 0; exe_rt = 0; exe_rw = 0; exe_regwr = 0; exe_memtoreg = 0;
      mem_rw = 0; mem_regwr = 0; mem_memtoreg = 0; wb_rw = 0; wb_regwr = 0;
      exe_mc_start = 0; exe_branch_taken = 0; id_jump = 0; cnt_clr = 0;
   endtask

   task automatic set_lu();
      exe_regwr = 1; exe_memtoreg = 1; exe_rw = 5; id_use_rs = 1; id_rs = 5;
   endtask

   task automatic clr_cycle();
      clear_inputs(); cnt_clr = 1; do_cycle(); cnt_clr = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      for (int k = 0; k < 2; k++) model_reset(k);
      @(negedge clk);
      // reset state
      set_lu(); exe_mc_start = 1;
      #1;
      check("rst.stall_pc", 32'(stall_pc[0]), 0);
      check("rst.mc_busy", 32'(mc_busy[1]), 0);
      check("rst.stall_cycles", dut_sc[0], 0);
      do_cycle();
      clear_inputs(); do_cycle();
      rst_n = 1'b1;
      do_cycle();

      // forwarding priority
      exe_rs = 3; mem_rw = 3; mem_regwr = 1; wb_rw = 3; wb_regwr = 1;
      #1 check("fwd.mem_wins", 32'(fwd_a[0]), 32'd1);
      do_cycle();
      mem_regwr = 0;
      #1 check("fwd.wb", 32'(fwd_a[0]), 32'd2);
      do_cycle();
      exe_rs = 0; mem_rw = 0; wb_rw = 0; mem_regwr = 1;
      #1 check("fwd.r0", 32'(fwd_a[0]), 32'd0);
      do_cycle();

      // load-use: one bubble for LOAD_LAT=1, three for LOAD_LAT=3
      clr_cycle();
      set_lu(); do_cycle();
      clear_inputs();
      repeat (4) do_cycle();
      check("lu.stall_cycles_lat1", dut_sc[0], 1);
      check("lu.stall_cycles_lat3", dut_sc[1], 3);

      // multi-cycle op with a second start while busy
      clr_cycle();
      busy_seen = 0;
      exe_mc_start = 1; do_cycle();
      exe_mc_start = 0; do_cycle();
      exe_mc_start = 1; do_cycle();
      exe_mc_start = 0;
      repeat (3) do_cycle();
      check("mc.stall_cycles", dut_sc[0], 4);
      check("mc.busy_cycles", 32'(busy_seen), 3);

      // taken branch overrides load-use
      clr_cycle();
      set_lu(); exe_branch_taken = 1;
      #1;
      check("br.flush", 32'(flush_if_id[1]), 1);
      check("br.bubble", 32'(bubble_id_exe[1]), 1);
      check("br.stall_pc", 32'(stall_pc[1]), 0);
      do_cycle();
      clear_inputs();
      #1 check("br.flush_count", dut_fc[1], 1);
      do_cycle();

      // reset during MC_BUSY with two busy cycles left
      exe_mc_start = 1; do_cycle();
      exe_mc_start = 0; do_cycle();
      rst_n = 1'b0;
      #1;
      check("rstmid.stall_pc", 32'(stall_pc[0]), 0);
      check("rstmid.mc_busy", 32'(mc_busy[0]), 0);
      check("rstmid.stall_cycles", dut_sc[0], 0);
      do_cycle();
      rst_n = 1'b1;
      #1 check("rstmid.resume", 32'(stall_pc[0]), 0);
      do_cycle();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         exe_rs = 5'($urandom_range(0, 3)); exe_rt = 5'($urandom_range(0, 3));
         exe_rw = 5'($urandom_range(0, 3)); mem_rw = 5'($urandom_range(0, 3));
         wb_rw = 5'($urandom_range(0, 3));
         id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
         exe_regwr = 1'($urandom); exe_memtoreg = 1'($urandom);
         mem_regwr = 1'($urandom); mem_memtoreg = 1'($urandom); wb_regwr = 1'($urandom);
         exe_mc_start = ($urandom_range(0, 9) == 0);
         exe_branch_taken = ($urandom_range(0, 5) == 0);
         id_jump = ($urandom_range(0, 3) == 0);
         cnt_clr = ($urandom_range(0, 40) == 0);
         do_cycle();
      end

      // counter saturation on the 4-bit instance
      clr_cycle();
      set_lu();
      repeat (20) do_cycle();
      clear_inputs();
      #1 check("sat.stall_cycles", dut_sc[1], 15);
      cnt_clr = 1; do_cycle();
      cnt_clr = 0;
      #1 check("sat.cleared", dut_sc[1], 0);
      do_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipelined CPU. It replaces the fixed one-cycle stall and forwarding logic with a single block. The block generates EXE-operand forwarding selects, multi-cycle load-use stalls, a multi-cycle-operation busy FSM and branch/jump flushes. It also keeps saturating stall and flush performance counters. It sits beside the pipeline registers and drives their stall and flush inputs.

Parameters:
RA_W, 5, register address width
LOAD_LAT, 1, bubble cycles required after a load before a dependent instruction may issue (1..7)
MC_LAT, 4, total EXE cycles of a multi-cycle op (MUL/DIV), 2..15
CNT_W, 16, width of performance counters

Ports:
CLK  in  1  pipeline clock, rising edge
Reset  in  1  asynchronous, active-low reset
id_rs, id_rt  in  RA_W  source registers of the instruction in ID
id_use_rs, id_use_rt  in  1  ID instruction actually reads rs/rt
exe_rs, exe_rt  in  RA_W  source registers of the instruction in EXE
exe_rw  in  RA_W  EXE destination; exe_regwr, exe_memtoreg  in  1 each
mem_rw  in  RA_W  MEM destination; mem_regwr, mem_memtoreg  in  1 each
wb_rw  in  RA_W  WB destination; wb_regwr  in  1
exe_mc_start  in  1  EXE holds a multi-cycle op in its first cycle
exe_branch_taken  in  1  branch resolved taken in EXE
id_jump  in  1  jump decoded in ID
cnt_clr  in  1  synchronous clear of counters
fwd_a, fwd_b  out  2  EXE operand select: 00 register file, 01 MEM_Result, 10 WB_BusW
stall_pc, stall_if_id, stall_id_exe  out  1  hold the respective register
bubble_id_exe, bubble_exe_mem  out  1  load a NOP into the register
flush_if_id  out  1  clear IF/ID
mc_busy  out  1  multi-cycle FSM not IDLE
stall_cycles, flush_count  out  CNT_W  performance counters

Behaviour:
- Reset (Reset=0, asynchronous): FSM to IDLE, load counter 0, both performance counters 0. All stall, bubble and flush outputs read 0; fwd_* depend only on inputs.
- Forwarding (combinational), fwd_a for exe_rs (fwd_b identical for exe_rt):
  - 01 if mem_regwr & !mem_memtoreg & mem_rw!=0 & mem_rw==exe_rs;
  - else 10 if wb_regwr & wb_rw!=0 & wb_rw==exe_rs;
  - else 00.
  - MEM wins over WB. Register 0 never forwards.
- Load-use hazard: lu = exe_regwr & exe_memtoreg & exe_rw!=0 & ((id_use_rs & id_rs==exe_rw) | (id_use_rt & id_rt==exe_rw)).
  - On lu in IDLE with LOAD_LAT>1: enter LD_WAIT with ld_cnt=LOAD_LAT-1.
  - Each cycle lu or LD_WAIT is active: stall_pc=stall_if_id=1 and bubble_id_exe=1.
  - LD_WAIT decrements ld_cnt and returns to IDLE at ld_cnt==1.
  - LOAD_LAT=1 gives exactly one bubble with no state entry.
- Multi-cycle FSM, states IDLE, MC_BUSY:
  - exe_mc_start in IDLE enters MC_BUSY with mc_cnt=MC_LAT-1.
  - In the start cycle and every MC_BUSY cycle: stall_pc, stall_if_id, stall_id_exe and bubble_exe_mem are 1.
  - mc_cnt decrements; when it reaches 0 the FSM returns to IDLE the next cycle.
  - Total stall is MC_LAT-1 cycles beyond the start cycle.
  - exe_mc_start is ignored while busy. mc_busy is 1 only in MC_BUSY.
- Branch: exe_branch_taken gives flush_if_id=1 and bubble_id_exe=1 in the same cycle. A taken branch overrides the load-use stall, aborts LD_WAIT to IDLE, and suppresses id_jump.
- Jump: id_jump alone gives flush_if_id=1 for one cycle.
- Priority, high to low: Reset, MC_BUSY/mc start, branch, load-use, jump. While a multi-cycle op is stalling, branch and jump inputs are ignored and no flush is driven.
- Counters:
  - stall_cycles increments every cycle stall_pc=1.
  - flush_count increments every cycle flush_if_id=1.
  - Both saturate at all-ones and never wrap.
  - cnt_clr zeroes both on the next edge and takes precedence over increment.

Decomposition:
- Shared package holds the fwd select constants (FWD_RF=00, FWD_MEM=01, FWD_WB=10), the FSM state enum (IDLE, LD_WAIT, MC_BUSY) and the default parameter constants.
- One sub-module, sat_counter (CNT_W, inc, clr), is instantiated twice for the performance counters.
- Forwarding stays inline.

Test Plan:
- Forwarding priority: exe_rs=3, mem_rw=3, mem_regwr=1, wb_rw=3, wb_regwr=1 -> fwd_a=01. Drop mem_regwr -> fwd_a=10. Set exe_rs=0 with all matches -> fwd_a=00.
- Load-use, LOAD_LAT=1: exe lw to $5, ID reads $5 -> one cycle with stall_pc=1, bubble_id_exe=1, stall_cycles=1. Repeat with LOAD_LAT=3 -> three stall cycles, stall_cycles=3.
- Multi-cycle op, MC_LAT=4: exe_mc_start pulse -> stall_pc high for 4 consecutive cycles, mc_busy high for 3, then all stalls 0. A second exe_mc_start mid-busy -> no extension.
- Branch vs load-use: exe_branch_taken=1 together with lu=1 -> flush_if_id=1, bubble_id_exe=1, stall_pc=0, flush_count=1.
- Reset mid-operation: Reset low during MC_BUSY at mc_cnt=2 -> outputs immediately 0, mc_busy=0, counters 0. After release the pipeline resumes with no stall.
- Saturation: CNT_W=4, hold stall for 20 cycles -> stall_cycles=15. Pulse cnt_clr -> 0.
